// File: rtl/uart_echo_ctrl.sv
// UART echo sequencer: receive FIFO feeding a start/busy transmitter handshake.
// Optional feature macro UART_ECHO_CRLF_EN inserts 0x0A after every transmitted 0x0D.
module uart_echo_ctrl #(
   parameter  int unsigned DEPTH = 16,
   localparam int unsigned LW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          enable,
   input  logic [7:0]    rx_data,
   input  logic          rx_valid,
   input  logic          tx_busy,
   output logic [7:0]    tx_data,
   output logic          tx_start,
   output logic [LW-1:0] level,
   output logic          overrun,
   output logic [7:0]    drop_cnt
);

   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic [2:0] {
      IDLE,
      START,
      WAIT_BUSY,
      WAIT_DONE
`ifdef UART_ECHO_CRLF_EN
      , INS_LF
`endif
   } state_t;

   state_t        state, next_state;
   logic [7:0]    mem [DEPTH];
   logic [LW-1:0] wr_ptr, rd_ptr;
   logic          empty, full, push, drop, pop, load_lf;

   // Pointers carry one extra MSB so full and empty are distinguishable.
   always_comb begin
      empty = (wr_ptr == rd_ptr);
      full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
      push  = rx_valid && !full;
      drop  = rx_valid && full;
      level = wr_ptr - rd_ptr;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:      if (pop) next_state = START;
         START:     next_state = WAIT_BUSY;
         WAIT_BUSY: if (tx_busy) next_state = WAIT_DONE;
         WAIT_DONE: begin
            if (!tx_busy) begin
`ifdef UART_ECHO_CRLF_EN
               next_state = (tx_data == 8'h0D) ? INS_LF : IDLE;
`else
               next_state = IDLE;
`endif
            end
         end
`ifdef UART_ECHO_CRLF_EN
         INS_LF:    next_state = START;
`endif
         default:   next_state = IDLE;
      endcase
   end

   always_comb begin
      tx_start = (state == START);
      pop      = (state == IDLE) && enable && !empty && !tx_busy;
`ifdef UART_ECHO_CRLF_EN
      load_lf  = (state == INS_LF);
`else
      load_lf  = 1'b0;
`endif
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= rx_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         tx_data  <= '0;
         overrun  <= 1'b0;
         drop_cnt <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr  <= rd_ptr + 1'b1;
            tx_data <= mem[rd_ptr[AW-1:0]];
         end else if (load_lf) begin
            tx_data <= 8'h0A;
         end
         overrun <= drop;
         if (drop && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_uart_echo_ctrl.sv
// Directed self-checking bench for uart_echo_ctrl with a simple transmitter busy model.
module tb_uart_echo_ctrl;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned LW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          enable;
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic          tx_busy;
   logic [7:0]    tx_data;
   logic          tx_start;
   logic [LW-1:0] level;
   logic          overrun;
   logic [7:0]    drop_cnt;

   int checks    = 0;
   int failures  = 0;
   int busy_len  = 4;
   int busy_cnt  = 0;
   int starts    = 0;
   int ov_cnt    = 0;
   int busy_viol = 0;
   logic [7:0] tx_log [$];
   logic [7:0] exp_q  [$];

   uart_echo_ctrl #(.DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .enable   (enable),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .tx_busy  (tx_busy),
      .tx_data  (tx_data),
      .tx_start (tx_start),
      .level    (level),
      .overrun  (overrun),
      .drop_cnt (drop_cnt)
   );

   always #5 clk = ~clk;

   assign tx_busy = (busy_cnt != 0);

   // Transmitter model: busy for busy_len cycles after each start; logs bytes.
   always @(negedge clk) begin
      if (rst) begin
         busy_cnt <= 0;
      end else begin
         if (tx_start) begin
            tx_log.push_back(tx_data);
            starts <= starts + 1;
            if (busy_cnt != 0) busy_viol <= busy_viol + 1;
            busy_cnt <= busy_len;
         end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
         end
         if (overrun) ov_cnt <= ov_cnt + 1;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      step();
      rx_valid = 1'b0;
   endtask

   task automatic wait_log(input int n, input int budget);
      for (int k = 0; k < budget && tx_log.size() < n; k++) step();
      chk("log_count", tx_log.size(), n);
   endtask

   task automatic wait_start(input int budget);
      for (int k = 0; k < budget && tx_start !== 1'b1; k++) step();
      chk("start_timeout", tx_start, 1);
   endtask

   task automatic cmp_log(input string tag);
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < tx_log.size()) chk(tag, tx_log[i], exp_q[i]);
         else                   chk(tag, 32'hDEAD, exp_q[i]);
      end
   endtask

   initial begin
      int ov0, st0, lvl;
      rst = 1'b1; enable = 1'b1; rx_data = 8'h00; rx_valid = 1'b0;
      repeat (3) step();
      chk("rst_level", level, 0);
      chk("rst_tx_start", tx_start, 0);
      chk("rst_tx_data", tx_data, 8'h00);
      chk("rst_overrun", overrun, 0);
      chk("rst_drop_cnt", drop_cnt, 0);
      rst = 1'b0;
      step();
      chk("post_rst_tx_start", tx_start, 0);

      // Single byte: push edge N, pop edge N+1, start in cycle N+2.
      rx_data = 8'h41; rx_valid = 1'b1;
      step();
      rx_valid = 1'b0;
      chk("single_level_push", level, 1);
      chk("single_no_early_start", tx_start, 0);
      step();
      chk("single_start", tx_start, 1);
      chk("single_data", tx_data, 8'h41);
      chk("single_level_pop", level, 0);
      step();
      chk("single_start_one_cycle", tx_start, 0);
      wait_log(1, 50);
      repeat (10) step();

      // Burst of 5 with a slow transmitter.
      tx_log.delete(); exp_q.delete();
      busy_len = 100; ov0 = ov_cnt;
      for (int i = 1; i <= 5; i++) begin
         push_byte(8'(i));
         exp_q.push_back(8'(i));
      end
      wait_log(5, 1500);
      cmp_log("burst_order");
      chk("burst_no_overrun", ov_cnt - ov0, 0);
      repeat (110) step();

      // Overflow with transmission disabled.
      tx_log.delete(); exp_q.delete();
      enable = 1'b0; busy_len = 3; ov0 = ov_cnt;
      for (int i = 0; i < 20; i++) begin
         push_byte(8'(8'h10 + i));
         chk("ovf_overrun_pulse", overrun, (i >= 16) ? 1 : 0);
         if (i < 16) exp_q.push_back(8'(8'h10 + i));
      end
      step();
      chk("ovf_level", level, 16);
      chk("ovf_drop_cnt", drop_cnt, 4);
      chk("ovf_pulses", ov_cnt - ov0, 4);
      chk("ovf_overrun_clear", overrun, 0);
      chk("ovf_no_tx_while_disabled", tx_log.size(), 0);
      enable = 1'b1;
      wait_log(16, 600);
      cmp_log("ovf_drain_order");
      chk("ovf_drained_level", level, 0);
      chk("ovf_drop_cnt_hold", drop_cnt, 4);
      repeat (20) step();

      // Wrap with coincident push/pop: period is busy_len+2 cycles per byte.
      tx_log.delete(); exp_q.delete();
      enable = 1'b0; busy_len = 4; ov0 = ov_cnt;
      for (int i = 0; i < 15; i++) begin
         push_byte(8'(8'h40 + i));
         exp_q.push_back(8'(8'h40 + i));
      end
      enable = 1'b1;
      wait_start(50);
      for (int j = 0; j < 25; j++) begin
         repeat (5) step();
         rx_data = 8'(8'h4F + j); rx_valid = 1'b1;
         exp_q.push_back(8'(8'h4F + j));
         lvl = int'(level);
         step();
         rx_valid = 1'b0;
         chk("wrap_coincident_start", tx_start, 1);
         chk("wrap_level_const", level, lvl);
      end
      wait_log(40, 400);
      cmp_log("wrap_order");
      chk("wrap_no_overrun", ov_cnt - ov0, 0);
      chk("wrap_final_level", level, 0);
      repeat (20) step();

      // Reset while in WAIT_DONE with 3 bytes queued.
      enable = 1'b0; busy_len = 50;
      for (int i = 0; i < 4; i++) push_byte(8'(8'h70 + i));
      enable = 1'b1;
      wait_start(50);
      repeat (2) step();
      chk("mid_level_before", level, 3);
      rst = 1'b1;
      step();
      chk("mid_rst_level", level, 0);
      chk("mid_rst_tx_start", tx_start, 0);
      chk("mid_rst_tx_data", tx_data, 8'h00);
      chk("mid_rst_drop_cnt", drop_cnt, 0);
      rst = 1'b0;
      st0 = starts;
      repeat (200) step();
      chk("mid_no_further_start", starts - st0, 0);
      chk("mid_level_after", level, 0);

      // CR handling: LF inserted only when the feature is built in.
      tx_log.delete(); exp_q.delete();
      busy_len = 4;
      exp_q.push_back(8'h0D);
`ifdef UART_ECHO_CRLF_EN
      exp_q.push_back(8'h0A);
`endif
      exp_q.push_back(8'h42);
      push_byte(8'h0D);
      push_byte(8'h42);
      wait_log(exp_q.size(), 200);
      repeat (30) step();
      chk("crlf_count_final", tx_log.size(), exp_q.size());
      cmp_log("crlf_sequence");
      chk("crlf_level", level, 0);

      chk("busy_overlap_violations", busy_viol, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
